// File: rtl/selector_41.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | selector_41 : registered 4-to-1 word selector, one cycle of latency         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module selector_41 #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  input  logic             iS0,
  input  logic             iS1,
  output logic [WIDTH-1:0] oZ
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_pick;
  logic [WIDTH-1:0] r_z;

  assign w_sel = {iS1, iS0};

  // An unknown select must propagate as X rather than hold the old word.
  always_comb begin
    w_pick = 'x;
    case (w_sel)
      2'b00:   w_pick = iC0;
      2'b01:   w_pick = iC1;
      2'b10:   w_pick = iC2;
      2'b11:   w_pick = iC3;
      default: w_pick = 'x;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_z <= '0;
    end else begin
      r_z <= w_pick;
    end
  end

  assign oZ = r_z;

endmodule
`default_nettype wire

// File: tb/tb_selector_41.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_selector_41 : directed checks of selector_41 at WIDTH=4 and WIDTH=8      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_selector_41;

  logic       clk;
  logic       rst;
  logic [3:0] c0, c1, c2, c3;
  logic       s0, s1;
  logic [3:0] z;
  logic [7:0] d0, d1, d2, d3;
  logic       t0, t1;
  logic [7:0] y;

  int testCount;
  int failCount;

  selector_41 #(.WIDTH(4)) dut4 (
    .iClk(clk), .iRst(rst),
    .iC0(c0), .iC1(c1), .iC2(c2), .iC3(c3),
    .iS0(s0), .iS1(s1), .oZ(z)
  );

  selector_41 #(.WIDTH(8)) dut8 (
    .iClk(clk), .iRst(rst),
    .iC0(d0), .iC1(d1), .iC2(d2), .iC3(d3),
    .iS0(t0), .iS1(t1), .oZ(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkResult(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] phaseSel [4];
    logic [1:0] sel;
    logic [7:0] pat;
    testCount = 0;
    failCount = 0;
    phaseSel[0] = 2'b00; phaseSel[1] = 2'b01;
    phaseSel[2] = 2'b11; phaseSel[3] = 2'b10;

    // Reset held two cycles with live data on the selected input
    rst = 1'b1;
    c0 = 4'hF; c1 = 4'h7; c2 = 4'h5; c3 = 4'h9; s1 = 1'b0; s0 = 1'b0;
    d0 = 8'hFF; d1 = 8'h11; d2 = 8'h22; d3 = 8'h33; t1 = 1'b0; t0 = 1'b0;
    step();
    checkResult("rst_edge1", {60'd0, z}, 64'h0);
    checkResult("rst8_edge1", {56'd0, y}, 64'h0);
    step();
    checkResult("rst_edge2", {60'd0, z}, 64'h0);

    // Static select sweep
    rst = 1'b0;
    c0 = 4'h1; c1 = 4'h2; c2 = 4'h4; c3 = 4'h8;
    {s1, s0} = 2'b00; step(); checkResult("sweep_00", {60'd0, z}, 64'h1);
    {s1, s0} = 2'b01; step(); checkResult("sweep_01", {60'd0, z}, 64'h2);
    {s1, s0} = 2'b10; step(); checkResult("sweep_10", {60'd0, z}, 64'h4);
    {s1, s0} = 2'b11; step(); checkResult("sweep_11", {60'd0, z}, 64'h8);

    // Walking one-hot across inputs, select fixed per 40-cycle phase
    for (int ph = 0; ph < 4; ph++) begin
      {s1, s0} = phaseSel[ph];
      for (int cyc = 0; cyc < 40; cyc++) begin
        c0 = (cyc % 4 == 0) ? 4'h1 : 4'h0;
        c1 = (cyc % 4 == 1) ? 4'h1 : 4'h0;
        c2 = (cyc % 4 == 2) ? 4'h1 : 4'h0;
        c3 = (cyc % 4 == 3) ? 4'h1 : 4'h0;
        step();
        checkResult("walk", {60'd0, z},
                    (2'(cyc % 4) == phaseSel[ph]) ? 64'h1 : 64'h0);
      end
    end

    // Select held at 10; only iC2 may influence the output
    {s1, s0} = 2'b10;
    c0 = 4'hE; c1 = 4'hD; c2 = 4'h3; c3 = 4'hB;
    step(); checkResult("hold_c2_3", {60'd0, z}, 64'h3);
    c0 = 4'h6; c1 = 4'h9; c2 = 4'hC; c3 = 4'h0;
    step(); checkResult("hold_c2_C", {60'd0, z}, 64'hC);
    c0 = 4'hF; c1 = 4'hF; c3 = 4'hF;
    step(); checkResult("hold_others", {60'd0, z}, 64'hC);

    // One-cycle reset pulse mid-stream
    {s1, s0} = 2'b11; c3 = 4'hA; c0 = 4'h0; c1 = 4'h0; c2 = 4'h0;
    step(); checkResult("mid_pre", {60'd0, z}, 64'hA);
    rst = 1'b1;
    step(); checkResult("mid_rst", {60'd0, z}, 64'h0);
    rst = 1'b0;
    step(); checkResult("mid_post", {60'd0, z}, 64'hA);

    // Wide instance: named pattern, then all-ones/all-zeros on every select
    d0 = 8'h00; d1 = 8'hA5; d2 = 8'h00; d3 = 8'h00;
    {t1, t0} = 2'b01;
    step(); checkResult("w8_A5", {56'd0, y}, 64'hA5);
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 2; p++) begin
        sel = 2'(s);
        pat = (p == 0) ? 8'hFF : 8'h00;
        d0 = (sel == 2'd0) ? pat : ~pat;
        d1 = (sel == 2'd1) ? pat : ~pat;
        d2 = (sel == 2'd2) ? pat : ~pat;
        d3 = (sel == 2'd3) ? pat : ~pat;
        {t1, t0} = sel;
        step();
        checkResult("w8_pat", {56'd0, y}, (p == 0) ? 64'hFF : 64'h00);
      end
    end
    // Distinct per-input words catch swapped or mixed bit lanes
    d0 = 8'h3C; d1 = 8'hC3; d2 = 8'h5A; d3 = 8'h96;
    {t1, t0} = 2'b10; step(); checkResult("w8_10", {56'd0, y}, 64'h5A);
    {t1, t0} = 2'b11; step(); checkResult("w8_11", {56'd0, y}, 64'h96);
    {t1, t0} = 2'b00; step(); checkResult("w8_00", {56'd0, y}, 64'h3C);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
